// File: rtl/result_display_if.sv
`default_nettype none
// ============================================================================
// Module   : result_display_if
// Brief    : Sample handshake, BCD result and display bus for result_display.
// Revision : 1.0  initial release
// ============================================================================
interface result_display_if;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic [6:0]  seg;
    logic [2:0]  an;

    modport master (
        output data_in, data_valid,
        input  busy, done, bcd, seg, an
    );

    modport slave (
        input  data_in, data_valid,
        output busy, done, bcd, seg, an
    );
endinterface
`default_nettype wire

// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
// Module   : result_display
// Brief    : Binary-to-BCD converter (double dabble) feeding a 3-digit
//            multiplexed seven-segment scan with leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  wire logic        clk,
    input  wire logic        rst,
    result_display_if.slave  disp
);

    localparam logic c_IDLE  = 1'b0;
    localparam logic c_SHIFT = 1'b1;

    localparam int c_CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_REF_MAX = c_CNT_W'(REFRESH_DIV - 1);

    logic        r_state;
    logic        w_next_state;
    logic        w_load;
    logic        w_shift;
    logic        w_finish;

    logic [7:0]  r_bin;
    logic [11:0] r_scratch;
    logic [2:0]  r_step;
    logic [11:0] r_bcd;
    logic        r_done;
    logic [11:0] w_adj;
    logic [19:0] w_shifted;

    logic [c_CNT_W-1:0] r_refresh;
    logic [1:0]  r_idx;
    logic [3:0]  w_nib;
    logic [2:0]  w_an_sel;
    logic        w_blank;
    logic [6:0]  w_seg_next;
    logic [2:0]  w_an_next;
    logic [6:0]  r_seg;
    logic [2:0]  r_an;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (disp.data_valid) w_next_state = c_SHIFT;
            c_SHIFT: if (r_step == 3'd7)  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            c_IDLE:  w_load = disp.data_valid;
            c_SHIFT: begin
                w_shift  = 1'b1;
                w_finish = (r_step == 3'd7);
            end
            default: ;
        endcase
    end

    // Add-3 correction on each nibble before it is doubled by the shift
    for (genvar i = 0; i < 3; i++) begin : g_adj
        assign w_adj[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5) ?
                                 r_scratch[4*i +: 4] + 4'd3 : r_scratch[4*i +: 4];
    end

    assign w_shifted = {w_adj[10:0], r_bin, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin     <= '0;
            r_scratch <= '0;
            r_step    <= '0;
            r_bcd     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_bin     <= disp.data_in;
                r_scratch <= '0;
                r_step    <= '0;
            end else if (w_shift) begin
                r_scratch <= w_shifted[19:8];
                r_bin     <= w_shifted[7:0];
                r_step    <= r_step + 3'd1;
                if (w_finish) begin
                    r_bcd  <= w_shifted[19:8];
                    r_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == c_REF_MAX) begin
            r_refresh <= '0;
            r_idx     <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // A digit is blank only while every more-significant digit is also zero
    always_comb begin
        w_nib    = 4'd0;
        w_an_sel = 3'b111;
        w_blank  = 1'b1;
        case (r_idx)
            2'd0: begin
                w_nib    = r_bcd[3:0];
                w_an_sel = 3'b110;
                w_blank  = 1'b0;
            end
            2'd1: begin
                w_nib    = r_bcd[7:4];
                w_an_sel = 3'b101;
                w_blank  = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
            end
            2'd2: begin
                w_nib    = r_bcd[11:8];
                w_an_sel = 3'b011;
                w_blank  = (r_bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
        w_seg_next = w_blank ? 7'b1111111 : seg_decode(w_nib);
        w_an_next  = w_blank ? 3'b111     : w_an_sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= 7'b1000000;
            r_an  <= 3'b110;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign disp.busy = (r_state == c_SHIFT);
    assign disp.done = r_done;
    assign disp.bcd  = r_bcd;
    assign disp.seg  = r_seg;
    assign disp.an   = r_an;

endmodule
`default_nettype wire
